// File: rtl/imem_loader.sv
// imem_loader: receives a little-endian byte stream containing a word count
// and then instruction words, and writes the words to instruction memory.
// The CPU is held in reset until the whole image has been written.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | collecting the 4-byte word count
// DATA  | collecting the 4 bytes of the next instruction word
// WRITE | single-cycle write of the assembled word
// DONE  | image complete, CPU released
// ERR   | word count exceeded DEPTH, waiting for start
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wen,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [31:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] byte_buf;
  logic        accept;
  logic        last_byte;
  logic [31:0] word;

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (bcnt == 2'd3);
  // The 4th byte is used directly from the input, so the 24-bit buffer is enough.
  assign word      = {in_data, byte_buf};

  // Next-state decode; start is ignored while a load is in progress.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (word == 32'd0)              state_n = S_DONE;
          else if (word > 32'(DEPTH))     state_n = S_ERR;
          else                            state_n = S_DATA;
        end
      end
      S_DATA:  if (last_byte) state_n = S_WRITE;
      S_WRITE: state_n = (idx == cnt - 32'd1) ? S_DONE : S_DATA;
      S_DONE:  if (start) state_n = S_LEN;
      S_ERR:   if (start) state_n = S_LEN;
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and outputs. Outputs are decoded from the next state so
  // that they are registered and line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      bcnt     <= '0;
      byte_buf <= '0;
      in_ready <= 1'b0;
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      state <= state_n;

      if (accept) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0:    byte_buf[7:0]   <= in_data;
          2'd1:    byte_buf[15:8]  <= in_data;
          2'd2:    byte_buf[23:16] <= in_data;
          default: ;
        endcase
      end

      if (state == S_LEN && last_byte) begin
        cnt <= word;
        idx <= '0;
      end

      if (state == S_DATA && last_byte) begin
        wdata <= word;
        waddr <= BASE_ADDR + (idx << 2);
      end

      if (state == S_WRITE && state_n == S_DATA)
        idx <= idx + 32'd1;

      in_ready <= (state_n == S_LEN) || (state_n == S_DATA);
      wen      <= (state_n == S_WRITE);
      busy     <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_WRITE);
      done     <= (state_n == S_DONE);
      err      <= (state_n == S_ERR);
      cpu_hold <= (state_n != S_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: expected writes are queued as the stream is
// driven and compared against each wen pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  imem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int          n_chk   = 0;
  int          n_pass  = 0;
  int          wen_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_wr;
  logic [31:0] prog[3] = '{32'h06400313, 32'h01400393, 32'h00730E33};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Every write pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wen_cnt++;
      check("in_ready_in_write", in_ready, 0);
      if (exp_q.size() == 0) begin
        check("pending_writes", 32'(exp_q.size()), 1);
      end else begin
        exp_wr = exp_q.pop_front();
        check("waddr", waddr, exp_wr[63:32]);
        check("wdata", wdata, exp_wr[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], stall ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic run_normal(input bit stall);
    pulse_start();
    send_word(32'd3, stall);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'(4 * i), prog[i]});
      send_word(prog[i], stall);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wen"},      wen, 0);
    check({tag, "_waddr"},    waddr, 0);
    check({tag, "_wdata"},    wdata, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // Normal load
    run_normal(1'b0);
    wait_done("normal_done");
    check("normal_cpu_hold", cpu_hold, 0);
    check("normal_busy", busy, 0);
    check("normal_wen_cnt", wen_cnt, 3);

    // Stalled source, same image
    run_normal(1'b1);
    wait_done("stall_done");
    check("stall_wen_cnt", wen_cnt, 6);
    check("stall_cpu_hold", cpu_hold, 0);

    // Empty image
    pulse_start();
    check("empty_cpu_hold_rise", cpu_hold, 1);
    check("empty_busy", busy, 1);
    send_word(32'd0, 1'b0);
    check("empty_done", done, 1);
    check("empty_cpu_hold", cpu_hold, 0);
    check("empty_wen_cnt", wen_cnt, 6);

    // Overflow: 1025 words
    pulse_start();
    send_word(32'd1025, 1'b0);
    check("ovf_err", err, 1);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_cpu_hold", cpu_hold, 1);
    check("ovf_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("ovf_err_held", err, 1);
    check("ovf_wen_cnt", wen_cnt, 6);
    pulse_start();
    check("ovf_restart_err", err, 0);
    check("ovf_restart_in_ready", in_ready, 1);
    check("ovf_restart_busy", busy, 1);
    send_word(32'd0, 1'b0);
    check("ovf_restart_done", done, 1);

    // Reset after the 2nd byte of the first data word
    pulse_start();
    send_word(32'd3, 1'b0);
    send_byte(prog[0][7:0], 0);
    send_byte(prog[0][15:8], 0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_idle_in_ready", in_ready, 0);
    check("midrst_idle_busy", busy, 0);
    check("midrst_wen_cnt", wen_cnt, 6);
    run_normal(1'b0);
    wait_done("reload_done");
    check("reload_wen_cnt", wen_cnt, 9);

    // Restart after done with a one-word image
    pulse_start();
    check("restart_cpu_hold", cpu_hold, 1);
    send_word(32'd1, 1'b0);
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    send_word(32'hDEADBEEF, 1'b0);
    wait_done("restart_done");
    check("restart_cpu_hold_low", cpu_hold, 0);
    check("restart_wen_cnt", wen_cnt, 10);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
